// File: rtl/blake2_io_pkg.sv
// Shared definitions for the BLAKE2b byte-serial I/O interface: command codes,
// sizes, transmit FSM states and the digest-length clamp.
package blake2_io_pkg;

  localparam logic [1:0] CMD_CONF  = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_DATA  = 2'd2;
  localparam logic [1:0] CMD_LAST  = 2'd3;

  localparam int unsigned BB = 64;
  localparam int unsigned W  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_e;

  // A zero or oversized request means "full-length digest".
  function automatic logic [6:0] clamp_len(input logic [7:0] nn, input int unsigned max_len);
    if (nn == 8'd0 || 32'(nn) > max_len) return 7'(max_len);
    return nn[6:0];
  endfunction

endpackage

// File: rtl/io_result_shreg.sv
// Load / shift-by-byte register holding the captured chaining state; the
// low byte is always the next digest byte. Optional parity via IO_RESULT_TX_PARITY_EN.
module io_result_shreg #(
  parameter int unsigned WIDTH = 512
) (
  input  logic             clk,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] load_data_i,
`ifdef IO_RESULT_TX_PARITY_EN
  output logic             parity_o,
`endif
  output logic [7:0]       data_o
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk) begin
    if (load_i)
      shreg <= load_data_i;
    else if (shift_i)
      shreg <= {8'h00, shreg[WIDTH-1:8]};
  end

  assign data_o = shreg[7:0];

`ifdef IO_RESULT_TX_PARITY_EN
  // Parity of the byte that will sit in data_o after this edge.
  logic parity;

  always_ff @(posedge clk) begin
    if (load_i)
      parity <= ^load_data_i[7:0];
    else if (shift_i)
      parity <= ^shreg[15:8];
  end

  assign parity_o = parity;
`endif

endmodule

// File: rtl/io_result_tx.sv
// Transmit side of the hash I/O: captures the final state and streams the
// first nn digest bytes LSB-first. Macro IO_RESULT_TX_PARITY_EN adds parity_o.
module io_result_tx
  import blake2_io_pkg::*;
#(
  parameter int unsigned BB = 64,
  parameter int unsigned W  = 64
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           hash_finished_i,
  input  logic [8*W-1:0] h_i,
  input  logic [7:0]     nn_i,
  input  logic           ready_i,
  output logic           valid_o,
  output logic [7:0]     data_o,
  output logic           last_o,
  output logic           busy_o,
  output logic           hash_finished_o
`ifdef IO_RESULT_TX_PARITY_EN
  ,
  output logic           parity_o
`endif
);

  tx_state_e  state;
  logic [6:0] remaining;
  logic [6:0] len;
  logic       load;
  logic       xfer;

  assign len  = clamp_len(nn_i, BB);
  assign load = (state == IDLE) && hash_finished_i;
  assign xfer = (state == SEND) && valid_o && ready_i;

`ifdef IO_RESULT_TX_PARITY_EN
  logic byte_parity;

  io_result_shreg #(.WIDTH(8*W)) u_shreg (
    .clk         (clk),
    .load_i      (load),
    .shift_i     (xfer),
    .load_data_i (h_i),
    .parity_o    (byte_parity),
    .data_o      (data_o)
  );

  assign parity_o = valid_o & byte_parity;
`else
  io_result_shreg #(.WIDTH(8*W)) u_shreg (
    .clk         (clk),
    .load_i      (load),
    .shift_i     (xfer),
    .load_data_i (h_i),
    .data_o      (data_o)
  );
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state           <= IDLE;
      remaining       <= '0;
      valid_o         <= 1'b0;
      last_o          <= 1'b0;
      busy_o          <= 1'b0;
      hash_finished_o <= 1'b0;
    end else begin
      hash_finished_o <= 1'b0;
      case (state)
        IDLE: begin
          if (hash_finished_i) begin
            remaining <= len;
            valid_o   <= 1'b1;
            busy_o    <= 1'b1;
            last_o    <= (len == 7'd1);
            state     <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            remaining <= remaining - 7'd1;
            if (remaining == 7'd1) begin
              valid_o         <= 1'b0;
              busy_o          <= 1'b0;
              last_o          <= 1'b0;
              hash_finished_o <= 1'b1;
              state           <= DONE;
            end else begin
              // last_o is precomputed so it flips together with the next byte.
              last_o <= (remaining == 7'd2);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/io_result_tx.md
Name: io_result_tx

Overview:
- Transmit side of the byte-serial hash I/O interface.
- When the core reports the hash finished, the block captures the final chaining state h[0..7] (8 x 64-bit words).
- It streams the first nn digest bytes out over an 8-bit valid/ready port, least-significant byte of h[0] first, as required by the BLAKE2b little-endian output.
- It sits beside the input-side interface, which provides nn, and reports completion to the outside.

Parameters:
- BB, 64: block/state size in bytes; also the maximum digest length.
- W, 64: word width in bits; the state is 8*W bits.

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- hash_finished_i  in  1  single-cycle pulse from the core: h_i is final and stable this cycle.
- h_i  in  512  final state; h_i[63:0] = h[0], h_i[511:448] = h[7].
- nn_i  in  8  digest length in bytes, sampled with hash_finished_i.
- ready_i  in  1  external sink accepts a byte this cycle.
- valid_o  out  1  data_o holds a digest byte.
- data_o  out  8  digest byte.
- last_o  out  1  qualifies the final byte (valid_o & last_o).
- busy_o  out  1  capture taken, transfer not complete.
- hash_finished_o  out  1  single-cycle pulse after the last byte's handshake.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; byte counter 0; shift register contents don't-care.
- Handshake: a byte transfers on a cycle with valid_o & ready_i.
  - Once asserted, valid_o stays high and data_o/last_o stay stable until the transfer.
  - ready_i may toggle freely; valid_o does not depend combinationally on ready_i.
- Length rule: len = (nn_i == 0 || nn_i > BB) ? BB : nn_i. The clamped value is latched into a 7-bit remaining counter at capture.
- FSM states:
  - IDLE: on hash_finished_i, load shift register <= h_i, remaining <= len, go to SEND. valid_o rises the following cycle (1-cycle capture latency). busy_o = 0.
  - SEND: valid_o = 1; data_o = shreg[7:0]; last_o = (remaining == 1).
    - On transfer: shreg >>= 8 and remaining -= 1.
    - If remaining was 1, go to DONE.
  - DONE: for one cycle, hash_finished_o = 1, busy_o = 0, valid_o = 0; then go to IDLE.
- busy_o is 1 exactly in SEND.
- Byte order: byte k output = h_i[8k+7:8k], k = 0..len-1. Bytes beyond len are never emitted.
- hash_finished_i while in SEND or DONE is ignored: no recapture, and the current transfer is not disturbed.
- hash_finished_i in the same cycle DONE returns to IDLE is also ignored. A new capture is accepted only in IDLE.
- The remaining counter never wraps: decrement only in SEND on transfer, and remaining >= 1 there.
- Reset mid-transfer: immediate abort to IDLE, valid_o = 0, no hash_finished_o pulse.
- Width: remaining is 7 bits (holds 64); the shift register is 512 bits with zero fill on shift.

Optional Feature:
- Macro: IO_RESULT_TX_PARITY_EN.
- Defined: extra output parity_o (1 bit) = ^data_o, registered alongside data_o. It is valid whenever valid_o is high and 0 when valid_o is low.
- Undefined: port absent; no parity logic.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package blake2_io_pkg holds:
  - CMD_CONF/CMD_START/CMD_DATA/CMD_LAST 2-bit constants.
  - BB = 64 and W = 64.
  - The tx state enum typedef (IDLE, SEND, DONE, 2-bit).
  - The len clamp function.
- One natural sub-module, io_result_shreg: a 512-bit load/shift-by-byte register with load_i, shift_i, data_o[7:0].
- The FSM and counter stay in io_result_tx.

Test Plan:
- h_i = {8{64'h0807060504030201}} with nn_i = 4, ready_i = 1:
  - Expect bytes 01,02,03,04 on four consecutive cycles starting 1 cycle after capture.
  - last_o on 04; hash_finished_o pulses one cycle after the 04 transfer; then busy_o = 0.
- nn_i = 0 and nn_i = 200 with incrementing bytes h byte k = k: expect exactly 64 bytes 00..3F, last_o only on 3F.
- Backpressure with nn_i = 8 and ready_i pattern 1,0,0,1,0,1...:
  - data_o/valid_o are held stable during ready_i = 0.
  - All 8 bytes are delivered in order with no duplicates or drops.
- A second hash_finished_i with different h_i mid-SEND: original stream completes unchanged and no recapture occurs.
- nreset asserted after byte 2 of 32: valid_o/busy_o drop immediately and no hash_finished_o is seen.
  - After release, a new capture with nn_i = 1 emits a single byte with last_o = 1.
- Parity build, data byte 8'hA5: parity_o = 0. Data byte 8'h01: parity_o = 1.
